// File: rtl/deflection_t_route.sv
// Routing and payload core of one deflection-routed T-switch (left, right, up ports).
// Optional feature: define ROUTE_RR_EN for a rotating priority pointer; otherwise the order is fixed l > r > u0.
module deflection_t_route #(
   parameter int N    = 4,
   parameter int A_W  = $clog2(N) + 1,
   parameter int D_W  = 32,
   parameter int posl = 0,
   parameter int posx = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             l_i_v,
   input  logic             l_i_defl,
   input  logic [A_W-1:0]   l_i_addr,
   input  logic [D_W-1:0]   l_i_d,
   input  logic             r_i_v,
   input  logic             r_i_defl,
   input  logic [A_W-1:0]   r_i_addr,
   input  logic [D_W-1:0]   r_i_d,
   input  logic             u0_i_v,
   input  logic             u0_i_defl,
   input  logic [A_W-1:0]   u0_i_addr,
   input  logic [D_W-1:0]   u0_i_d,
   output logic             l_o_v,
   output logic             l_o_defl,
   output logic [2:0]       l_sel,
   output logic [A_W+D_W-1:0] l_o_c,
   output logic             r_o_v,
   output logic             r_o_defl,
   output logic [2:0]       r_sel,
   output logic [A_W+D_W-1:0] r_o_c,
   output logic             u0_o_v,
   output logic             u0_o_defl,
   output logic [2:0]       u0_sel,
   output logic [A_W+D_W-1:0] u0_o_c
);

   localparam int K   = $clog2(N);
   localparam int C_W = A_W + D_W;

   function automatic logic [C_W-1:0] mux2(input logic s, input logic [C_W-1:0] i0,
                                           input logic [C_W-1:0] i1);
      return s ? i1 : i0;
   endfunction

   // Select code 3 falls through to the zero leg.
   function automatic logic [C_W-1:0] mux3(input logic [1:0] s, input logic [C_W-1:0] i0,
                                           input logic [C_W-1:0] i1, input logic [C_W-1:0] i2);
      return mux2(s[1], mux2(s[0], i0, i1), mux2(s[0], i2, {C_W{1'b0}}));
   endfunction

   function automatic logic [1:0] route(input logic [K-1:0] a);
      logic in_sub;
      if (posl + 1 >= K) in_sub = 1'b1;
      else               in_sub = ((a >> (posl + 1)) == K'(posx));
      if (!in_sub)       return 2'd2;
      else if (a[posl])  return 2'd1;
      else               return 2'd0;
   endfunction

   logic [2:0]     in_v_s;
   logic [2:0]     in_defl_s;
   logic [1:0]     des_s [3];
   logic [C_W-1:0] in_c_s [3];
   logic [1:0]     p_eff_s;
   logic [2:0]     sel_s [3];
   logic [2:0]     odefl_s;
   logic [2:0]     used_s;
   logic [2:0]     idx_s;
   logic [1:0]     port_s;
   logic [1:0]     free_s;
   logic           grp_s;

   assign in_v_s    = {u0_i_v, r_i_v, l_i_v};
   assign in_defl_s = {u0_i_defl, r_i_defl, l_i_defl};
   assign des_s[0]  = route(l_i_addr[K-1:0]);
   assign des_s[1]  = route(r_i_addr[K-1:0]);
   assign des_s[2]  = route(u0_i_addr[K-1:0]);
   assign in_c_s[0] = {l_i_addr, l_i_d};
   assign in_c_s[1] = {r_i_addr, r_i_d};
   assign in_c_s[2] = {u0_i_addr, u0_i_d};

`ifdef ROUTE_RR_EN
   logic [1:0] p_r;

   // Rotating priority pointer; a stray value 3 acts as l and reloads l on advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_r <= 2'd0;
      end else if (ce && (|in_v_s)) begin
         case (p_r)
            2'd0:    p_r <= 2'd1;
            2'd1:    p_r <= 2'd2;
            default: p_r <= 2'd0;
         endcase
      end else begin
         p_r <= p_r;
      end
   end

   assign p_eff_s = (p_r == 2'd3) ? 2'd0 : p_r;
`else
   logic unused_s;
   assign unused_s = ^{clk, rst, ce};
   assign p_eff_s  = 2'd0;
`endif

   // Allocate outputs: deflected packets first, then fresh ones, each group in pointer order.
   always_comb begin
      used_s  = 3'b000;
      odefl_s = 3'b000;
      idx_s   = 3'd0;
      port_s  = 2'd0;
      free_s  = 2'd0;
      grp_s   = 1'b0;
      for (int o = 0; o < 3; o++) sel_s[o] = 3'b000;
      for (int g = 0; g < 2; g++) begin
         grp_s = (g == 0) ? 1'b1 : 1'b0;
         for (int k = 0; k < 3; k++) begin
            idx_s = {1'b0, p_eff_s} + 3'(k);
            if (idx_s >= 3'd3) idx_s = idx_s - 3'd3;
            else               idx_s = idx_s;
            port_s = idx_s[1:0];
            if (in_v_s[port_s] && (in_defl_s[port_s] == grp_s)) begin
               if (!used_s[des_s[port_s]]) begin
                  used_s[des_s[port_s]] = 1'b1;
                  sel_s[des_s[port_s]]  = {1'b1, port_s};
               end else begin
                  if (!used_s[0])      free_s = 2'd0;
                  else if (!used_s[1]) free_s = 2'd1;
                  else                 free_s = 2'd2;
                  used_s[free_s]  = 1'b1;
                  odefl_s[free_s] = 1'b1;
                  sel_s[free_s]   = {1'b1, port_s};
               end
            end else begin
               free_s = free_s;
            end
         end
      end
   end

   assign l_o_v     = sel_s[0][2];
   assign l_o_defl  = odefl_s[0];
   assign l_sel     = sel_s[0];
   assign l_o_c     = mux3(sel_s[0][1:0], in_c_s[0], in_c_s[1], in_c_s[2]);
   assign r_o_v     = sel_s[1][2];
   assign r_o_defl  = odefl_s[1];
   assign r_sel     = sel_s[1];
   assign r_o_c     = mux3(sel_s[1][1:0], in_c_s[0], in_c_s[1], in_c_s[2]);
   assign u0_o_v    = sel_s[2][2];
   assign u0_o_defl = odefl_s[2];
   assign u0_sel    = sel_s[2];
   assign u0_o_c    = mux3(sel_s[2][1:0], in_c_s[0], in_c_s[1], in_c_s[2]);

endmodule

// File: tb/tb_deflection_t_route.sv
// Directed bench for deflection_t_route (N=4, posl=0, posx=1) with a queue-based allocation model.
`timescale 1ns/1ps
module tb_deflection_t_route;
   localparam int N = 4, A_W = 3, D_W = 32, C_W = 35, K = 2, POSL = 0, POSX = 1;
`ifdef ROUTE_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0, rst = 1'b1, ce = 1'b0;
   logic iv [3], idf [3];
   logic [A_W-1:0] ia [3];
   logic [D_W-1:0] id [3];
   logic ov [3], odf [3];
   logic [2:0] osel [3];
   logic [C_W-1:0] oc [3];
   int total = 0, bad = 0, mp = 0;
   bit check_en = 1'b0;
   int m_owner [3];
   bit m_defl [3];
   string pn [3] = '{"l", "r", "u0"};

   always #5 clk = ~clk;

   deflection_t_route #(.N(N), .A_W(A_W), .D_W(D_W), .posl(POSL), .posx(POSX)) dut (
      .clk(clk), .rst(rst), .ce(ce),
      .l_i_v(iv[0]), .l_i_defl(idf[0]), .l_i_addr(ia[0]), .l_i_d(id[0]),
      .r_i_v(iv[1]), .r_i_defl(idf[1]), .r_i_addr(ia[1]), .r_i_d(id[1]),
      .u0_i_v(iv[2]), .u0_i_defl(idf[2]), .u0_i_addr(ia[2]), .u0_i_d(id[2]),
      .l_o_v(ov[0]), .l_o_defl(odf[0]), .l_sel(osel[0]), .l_o_c(oc[0]),
      .r_o_v(ov[1]), .r_o_defl(odf[1]), .r_sel(osel[1]), .r_o_c(oc[1]),
      .u0_o_v(ov[2]), .u0_o_defl(odf[2]), .u0_sel(osel[2]), .u0_o_c(oc[2])
   );

   // Model pointer: counts accepted advances modulo three.
   always @(posedge clk or posedge rst) begin
      if (rst) mp <= 0;
      else if (RR && ce && (iv[0] || iv[1] || iv[2])) mp <= (mp + 1) % 3;
   end

   function automatic int dest(logic [A_W-1:0] addr);
      int a;
      a = int'(addr) % N;
      if ((POSL + 1 >= K) || (a / (2 ** (POSL + 1)) == POSX)) return (a / (2 ** POSL)) % 2;
      return 2;
   endfunction

   task automatic run_model();
      int order [$];
      int f;
      for (int o = 0; o < 3; o++) begin m_owner[o] = -1; m_defl[o] = 1'b0; end
      for (int g = 1; g >= 0; g--)
         for (int k = 0; k < 3; k++) begin
            int p;
            p = (mp + k) % 3;
            if (iv[p] && int'(idf[p]) == g) order.push_back(p);
         end
      foreach (order[j]) begin
         int p, d;
         p = order[j];
         d = dest(ia[p]);
         if (m_owner[d] < 0) m_owner[d] = p;
         else begin
            f = 0;
            while (m_owner[f] >= 0) f++;
            m_owner[f] = p;
            m_defl[f]  = 1'b1;
         end
      end
   endtask

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Every settled cycle out of reset, the DUT must match the model on all ports.
   always @(negedge clk) begin
      if (check_en && !rst) begin
         run_model();
         for (int o = 0; o < 3; o++) begin
            chk({"m_", pn[o], "_v"}, ov[o], (m_owner[o] >= 0));
            chk({"m_", pn[o], "_defl"}, odf[o], m_defl[o]);
            chk({"m_", pn[o], "_sel"}, osel[o], (m_owner[o] >= 0) ? {1'b1, 2'(m_owner[o])} : 3'b000);
            if (m_owner[o] >= 0)
               chk({"m_", pn[o], "_c"}, oc[o], {ia[m_owner[o]], id[m_owner[o]]});
         end
      end
   end

   task automatic lit(string nm, int o, logic [2:0] sel, bit defl);
      chk({nm, "_", pn[o], "_sel"}, osel[o], sel);
      chk({nm, "_", pn[o], "_v"}, ov[o], sel[2]);
      chk({nm, "_", pn[o], "_defl"}, odf[o], defl);
   endtask

   task automatic clr();
      for (int p = 0; p < 3; p++) begin iv[p] = 1'b0; idf[p] = 1'b0; ia[p] = '0; id[p] = '0; end
   endtask

   task automatic put(int p, logic [A_W-1:0] a, bit df, logic [D_W-1:0] d);
      iv[p] = 1'b1; idf[p] = df; ia[p] = a; id[p] = d;
   endtask

   task automatic go();
      @(posedge clk); #1;
   endtask

   task automatic settle();
      @(negedge clk); #1;
   endtask

   initial begin
      int ep;
      clr();
      repeat (2) @(posedge clk);
      settle();
      for (int o = 0; o < 3; o++) lit("rst", o, 3'b000, 1'b0);
      go(); rst = 1'b0; check_en = 1'b1;

      go(); clr(); put(0, 3'd3, 1'b0, 32'hA1A1_0001); settle();
      lit("s1", 1, 3'b100, 1'b0); lit("s1", 0, 3'b000, 1'b0); lit("s1", 2, 3'b000, 1'b0);
      chk("s1_r_c", oc[1], {3'd3, 32'hA1A1_0001});

      go(); clr(); put(1, 3'd0, 1'b0, 32'hB2B2_0002); settle();
      lit("s2", 2, 3'b101, 1'b0);
      chk("s2_u0_c", oc[2], {3'd0, 32'hB2B2_0002});

      go(); clr(); put(0, 3'd2, 1'b0, 32'h0000_0C01); put(1, 3'd2, 1'b0, 32'h0000_0C02); ce = 1'b1; settle();
      lit("s3a", 0, 3'b100, 1'b0); lit("s3a", 1, 3'b101, 1'b1);
      go(); ce = 1'b0; settle();
      lit("s3b", 0, RR ? 3'b101 : 3'b100, 1'b0); lit("s3b", 1, RR ? 3'b100 : 3'b101, 1'b1);

      go(); #1 rst = 1'b1; #2 rst = 1'b0; settle();
      lit("arst", 0, 3'b100, 1'b0); lit("arst", 1, 3'b101, 1'b1);

      go(); clr(); put(2, 3'd2, 1'b1, 32'h0000_0D02); put(0, 3'd2, 1'b0, 32'h0000_0D00); settle();
      lit("s4", 0, 3'b110, 1'b0); lit("s4", 1, 3'b100, 1'b1); lit("s4", 2, 3'b000, 1'b0);

      go(); clr(); put(0, 3'd0, 1'b0, 32'h0000_0E00); put(1, 3'd1, 1'b0, 32'h0000_0E01);
      put(2, 3'd4, 1'b0, 32'h0000_0E02); settle();
      lit("s5", 2, 3'b100, 1'b0); lit("s5", 0, 3'b101, 1'b1); lit("s5", 1, 3'b110, 1'b1);

      for (int i = 0; i < 3; i++) begin
         go(); settle();
         lit("ce0", 2, 3'b100, 1'b0);
      end
      ce = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         go(); settle();
         ep = RR ? (i % 3) : 0;
         lit("rot", 2, {1'b1, 2'(ep)}, 1'b0);
         lit("rot", 0, {1'b1, 2'((ep + 1) % 3)}, 1'b1);
         lit("rot", 1, {1'b1, 2'((ep + 2) % 3)}, 1'b1);
      end

      for (int i = 0; i < 12; i++) begin
         go(); clr();
         for (int p = 0; p < 3; p++)
            if ((i + p) % 4 != 0) put(p, 3'((i * 3 + p * 5) % 8), ((i * p) % 3) == 1, 32'h1000 * i + p);
         settle();
      end

      go(); clr(); ce = 1'b0; settle();
      check_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
